// File: rtl/param_acc_cpu.sv
// Parametrised multi-cycle accumulator CPU. One req/ack memory port is shared
// by instruction fetch and data access; flags, conditional jumps and HALT.
`timescale 1ns/1ps
module param_acc_cpu #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ADDR_W-1:0]  i_start_addr,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  input  logic               i_mem_ack,
  output logic [DATA_W-1:0]  o_ac,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [3:0]         o_operation,
  output logic               o_pc_en,
  output logic               o_carry,
  output logic               o_zero,
  output logic               o_halted
);

  localparam int OPND_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [3:0]          r_opcode, w_opcode_next;
  logic [OPND_W-1:0]   r_operand, w_operand_next;
  logic [DATA_W-1:0]   r_ac, w_ac_next;
  logic                r_carry, w_carry_next;
  logic                r_zero, w_zero_next;

  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_is_mem_op;
  logic [DATA_W-1:0]   w_src;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic                w_borrow;
  logic [DATA_W-1:0]   w_alu_ac;
  logic                w_alu_carry;
  logic                w_alu_wr;
  logic                w_alu_zero;

  assign w_imm       = r_operand[DATA_W-1:0];
  assign w_addr      = r_operand[ADDR_W-1:0];
  assign w_is_mem_op = (r_opcode >= OP_LDA) && (r_opcode <= OP_XOR);

  // Memory ops take their operand from the data bus, everything else from imm.
  assign w_src    = (r_state == ST_MEM) ? i_mem_rdata[DATA_W-1:0] : w_imm;
  assign w_sum    = {1'b0, r_ac} + {1'b0, w_src};
  assign w_diff   = r_ac - w_src;
  assign w_borrow = (r_ac < w_src);

  generate
    if (INSTR_W > 4 + OPND_W) begin : g_pad
      logic w_unused_instr_bits;
      assign w_unused_instr_bits = &{1'b0, i_mem_rdata[INSTR_W-5:OPND_W]};
    end
  endgenerate

  always_comb begin
    w_alu_ac    = r_ac;
    w_alu_carry = r_carry;
    w_alu_wr    = 1'b0;
    case (r_opcode)
      OP_LDI: begin
        w_alu_ac = w_imm;
        w_alu_wr = 1'b1;
      end
      OP_LDA: begin
        w_alu_ac = w_src;
        w_alu_wr = 1'b1;
      end
      OP_ADD, OP_ADDI: begin
        w_alu_ac    = w_sum[DATA_W-1:0];
        w_alu_carry = w_sum[DATA_W];
        w_alu_wr    = 1'b1;
      end
      OP_SUB: begin
        w_alu_ac    = w_diff;
        w_alu_carry = w_borrow;
        w_alu_wr    = 1'b1;
      end
      OP_AND: begin
        w_alu_ac = r_ac & w_src;
        w_alu_wr = 1'b1;
      end
      OP_OR: begin
        w_alu_ac = r_ac | w_src;
        w_alu_wr = 1'b1;
      end
      OP_XOR: begin
        w_alu_ac = r_ac ^ w_src;
        w_alu_wr = 1'b1;
      end
      OP_SHL: begin
        w_alu_ac    = {r_ac[DATA_W-2:0], 1'b0};
        w_alu_carry = r_ac[DATA_W-1];
        w_alu_wr    = 1'b1;
      end
      OP_SHR: begin
        w_alu_ac    = {1'b0, r_ac[DATA_W-1:1]};
        w_alu_carry = r_ac[0];
        w_alu_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_alu_zero = (w_alu_ac == '0);

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_opcode_next  = r_opcode;
    w_operand_next = r_operand;
    w_ac_next      = r_ac;
    w_carry_next   = r_carry;
    w_zero_next    = r_zero;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_pc_en        = 1'b0;
    o_halted       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_pc_next    = i_start_addr;
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_pc;
        if (i_mem_ack) begin
          w_opcode_next  = i_mem_rdata[INSTR_W-1 -: 4];
          w_operand_next = i_mem_rdata[OPND_W-1:0];
          w_pc_next      = r_pc + ADDR_W'(1);
          o_pc_en        = 1'b1;
          w_state_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_is_mem_op) begin
          w_state_next = ST_MEM;
        end else begin
          w_state_next = ST_FETCH;
          case (r_opcode)
            OP_JMP: w_pc_next = w_addr;
            OP_JZ:  if (r_zero)  w_pc_next = w_addr;
            OP_JC:  if (r_carry) w_pc_next = w_addr;
            OP_HLT: w_state_next = ST_HALT;
            default: ;
          endcase
          if (w_alu_wr) begin
            w_ac_next    = w_alu_ac;
            w_carry_next = w_alu_carry;
            w_zero_next  = w_alu_zero;
          end
        end
      end
      ST_MEM: begin
        // Address/data come straight from registers, so they hold until ack.
        o_mem_req  = 1'b1;
        o_mem_we   = (r_opcode == OP_STA);
        o_mem_addr = w_addr;
        if (r_opcode == OP_STA) o_mem_wdata = r_ac;
        if (i_mem_ack) begin
          w_state_next = ST_FETCH;
          if (w_alu_wr) begin
            w_ac_next    = w_alu_ac;
            w_carry_next = w_alu_carry;
            w_zero_next  = w_alu_zero;
          end
        end
      end
      ST_HALT: o_halted = 1'b1;
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_INIT;
      r_pc      <= '0;
      r_opcode  <= OP_NOP;
      r_operand <= '0;
      r_ac      <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_opcode  <= w_opcode_next;
      r_operand <= w_operand_next;
      r_ac      <= w_ac_next;
      r_carry   <= w_carry_next;
      r_zero    <= w_zero_next;
    end
  end

  assign o_ac        = r_ac;
  assign o_pc        = r_pc;
  assign o_operation = r_opcode;
  assign o_carry     = r_carry;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_param_acc_cpu.sv
// Directed bench for param_acc_cpu: an 8/8/16 instance with a wait-state memory
// model and a 12/10/16 instance with a zero-wait memory.
`timescale 1ns/1ps
module tb_param_acc_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0]  start_a, addr_a, wdata_a, ac_a, pc_a;
  logic        req_a, we_a, ack_a, pc_en_a, carry_a, zero_a, halted_a;
  logic [15:0] rdata_a;
  logic [3:0]  op_a;

  logic [9:0]  start_b, addr_b, pc_b;
  logic [11:0] wdata_b, ac_b;
  logic        req_b, we_b, ack_b, pc_en_b, carry_b, zero_b, halted_b;
  logic [15:0] rdata_b;
  logic [3:0]  op_b;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:1023];
  int ack_delay;
  int wait_cnt;
  int checks = 0;
  int failures = 0;
  logic [7:0] wr_addr, wr_data;
  int wr_count = 0;

  localparam logic [17:0] ALU_EXP [0:13] = '{
    {8'h20, 8'h00, 2'b00}, {8'h21, 8'h81, 2'b00}, {8'h22, 8'h02, 2'b10},
    {8'h30, 8'h02, 2'b10}, {8'h31, 8'h01, 2'b00}, {8'h32, 8'h01, 2'b00},
    {8'h33, 8'h00, 2'b11}, {8'h34, 8'h0F, 2'b10}, {8'h35, 8'h0C, 2'b10},
    {8'h36, 8'h3C, 2'b10}, {8'h37, 8'h3C, 2'b10}, {8'h38, 8'h00, 2'b11},
    {8'h39, 8'hFF, 2'b10}, {8'h3A, 8'hFF, 2'b10}
  };
  localparam logic [23:0] WIDE_EXP [0:3] = '{
    {10'h200, 12'h000, 2'b00}, {10'h201, 12'hFF0, 2'b00},
    {10'h202, 12'h010, 2'b10}, {10'h203, 12'h000, 2'b01}
  };

  param_acc_cpu #(.DATA_W(8), .ADDR_W(8), .INSTR_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start_addr(start_a),
    .o_mem_req(req_a), .o_mem_we(we_a), .o_mem_addr(addr_a), .o_mem_wdata(wdata_a),
    .i_mem_rdata(rdata_a), .i_mem_ack(ack_a),
    .o_ac(ac_a), .o_pc(pc_a), .o_operation(op_a), .o_pc_en(pc_en_a),
    .o_carry(carry_a), .o_zero(zero_a), .o_halted(halted_a)
  );

  param_acc_cpu #(.DATA_W(12), .ADDR_W(10), .INSTR_W(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start_addr(start_b),
    .o_mem_req(req_b), .o_mem_we(we_b), .o_mem_addr(addr_b), .o_mem_wdata(wdata_b),
    .i_mem_rdata(rdata_b), .i_mem_ack(ack_b),
    .o_ac(ac_b), .o_pc(pc_b), .o_operation(op_b), .o_pc_en(pc_en_b),
    .o_carry(carry_b), .o_zero(zero_b), .o_halted(halted_b)
  );

  // Memory A acks after ack_delay cycles of a held request.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!req_a || ack_a) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign ack_a   = req_a && (wait_cnt >= ack_delay);
  assign rdata_a = mem_a[addr_a];
  assign ack_b   = req_b;
  assign rdata_b = mem_b[addr_b];

  always @(posedge clk) begin
    if (req_a && we_a && ack_a) begin
      wr_addr  <= addr_a;
      wr_data  <= wdata_a;
      wr_count <= wr_count + 1;
    end
  end

  task automatic step_a(output logic [7:0] addr, output int cycles, output bit timeout);
    addr = 8'h00;
    cycles = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (pc_en_a) begin
        addr = addr_a;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_reset(input logic [7:0] sa, input logic [9:0] sb);
    rst = 1'b1;
    start_a = sa;
    start_b = sb;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_a = 8'h06;
    start_b = 10'h000;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_a, we_a, addr_a, wdata_a, ac_a, pc_a, op_a, pc_en_a, carry_a, zero_a, halted_a} !== 42'd0)
      begin failures++; $display("FAIL reset_outputs: got req=%b ac=%h pc=%h op=%h h=%b, want all 0", req_a, ac_a, pc_a, op_a, halted_a); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_a !== 1'b0 || pc_a !== 8'h00)
      begin failures++; $display("FAIL init_cycle: got req=%b pc=%h, want req=0 pc=00", req_a, pc_a); end
    @(negedge clk);
    checks++;
    if ({req_a, we_a, addr_a, pc_en_a} !== {1'b1, 1'b0, 8'h06, 1'b1})
      begin failures++; $display("FAIL first_fetch: got req=%b we=%b addr=%h pc_en=%b, want 1 0 06 1", req_a, we_a, addr_a, pc_en_a); end
    @(negedge clk);
    checks++;
    if ({pc_a, op_a, pc_en_a} !== {8'h07, 4'h1, 1'b0})
      begin failures++; $display("FAIL pc_after_fetch: got pc=%h op=%h pc_en=%b, want 07 1 0", pc_a, op_a, pc_en_a); end
  endtask

  task automatic test_arith;
    logic [7:0] a; int cyc; bit to;
    step_a(a, cyc, to);
    checks++;
    if (to || {a, ac_a, carry_a, zero_a} !== {8'h07, 8'hF0, 2'b00})
      begin failures++; $display("FAIL ldi: got addr=%h ac=%h c=%b z=%b to=%b, want 07 F0 0 0", a, ac_a, carry_a, zero_a, to); end
    step_a(a, cyc, to);
    checks++;
    if (to || cyc != 2 || {a, ac_a, carry_a, zero_a} !== {8'h08, 8'h10, 2'b10})
      begin failures++; $display("FAIL addi: got addr=%h ac=%h c=%b z=%b cyc=%0d, want 08 10 1 0 cyc=2", a, ac_a, carry_a, zero_a, cyc); end
    step_a(a, cyc, to);
    checks++;
    if (to || cyc != 3 || {a, ac_a, carry_a, zero_a} !== {8'h09, 8'h00, 2'b01})
      begin failures++; $display("FAIL sub: got addr=%h ac=%h c=%b z=%b cyc=%0d, want 09 00 0 1 cyc=3", a, ac_a, carry_a, zero_a, cyc); end
  endtask

  task automatic test_branch;
    logic [7:0] a; int cyc; bit to;
    step_a(a, cyc, to);
    checks++;
    if (to || a !== 8'h40)
      begin failures++; $display("FAIL jz_taken: got fetch addr=%h to=%b, want 40", a, to); end
    step_a(a, cyc, to);
    checks++;
    if (to || {a, ac_a, zero_a} !== {8'h41, 8'h05, 1'b0})
      begin failures++; $display("FAIL ldi5: got addr=%h ac=%h z=%b, want 41 05 0", a, ac_a, zero_a); end
    step_a(a, cyc, to);
    checks++;
    if (to || a !== 8'h42 || pc_a !== 8'h42)
      begin failures++; $display("FAIL jz_not_taken: got addr=%h pc=%h, want 42 42", a, pc_a); end
  endtask

  task automatic test_wait_states;
    @(posedge clk);
    #1 ack_delay = 3;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({req_a, we_a, addr_a, ac_a, ack_a} !== {1'b1, 1'b0, 8'h81, 8'h05, (k == 3)})
        begin failures++; $display("FAIL lda_wait%0d: got req=%b we=%b addr=%h ac=%h ack=%b, want 1 0 81 05 %0d", k, req_a, we_a, addr_a, ac_a, ack_a, k == 3); end
    end
    ack_delay = 0;
    @(negedge clk);
    checks++;
    if ({pc_en_a, addr_a, ac_a, zero_a, carry_a} !== {1'b1, 8'h43, 8'h3C, 2'b00})
      begin failures++; $display("FAIL lda_result: got pc_en=%b addr=%h ac=%h z=%b c=%b, want 1 43 3C 0 0", pc_en_a, addr_a, ac_a, zero_a, carry_a); end
  endtask

  task automatic test_wrap_halt;
    logic [7:0] a; int cyc; bit to; bit bad;
    step_a(a, cyc, to);
    checks++;
    if (to || a !== 8'hFF)
      begin failures++; $display("FAIL jmp_ff: got addr=%h, want FF", a); end
    step_a(a, cyc, to);
    checks++;
    if (to || a !== 8'h00 || pc_a !== 8'h00)
      begin failures++; $display("FAIL pc_wrap: got addr=%h pc=%h, want 00 00", a, pc_a); end
    repeat (2) @(negedge clk);
    checks++;
    if ({halted_a, req_a, op_a} !== {1'b1, 1'b0, 4'hF})
      begin failures++; $display("FAIL halt_enter: got halted=%b req=%b op=%h, want 1 0 F", halted_a, req_a, op_a); end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_a !== 1'b0 || halted_a !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad)
      begin failures++; $display("FAIL halt_hold: got a request or halted drop, want idle"); end
  endtask

  task automatic test_reset_during_sta;
    logic [7:0] a; int cyc; bit to; int wc0;
    pulse_reset(8'h10, 10'h000);
    step_a(a, cyc, to);
    step_a(a, cyc, to);
    @(posedge clk);
    #1 ack_delay = 5;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_a, we_a, addr_a, wdata_a} !== {1'b1, 1'b1, 8'h83, 8'hA5})
      begin failures++; $display("FAIL sta_req: got req=%b we=%b addr=%h wdata=%h, want 1 1 83 A5", req_a, we_a, addr_a, wdata_a); end
    wc0 = wr_count;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_a, we_a, addr_a, wdata_a, ac_a, pc_a, op_a, pc_en_a, carry_a, zero_a, halted_a} !== 42'd0)
      begin failures++; $display("FAIL rst_mid_sta: got req=%b we=%b addr=%h ac=%h pc=%h op=%h, want all 0", req_a, we_a, addr_a, ac_a, pc_a, op_a); end
    @(negedge clk);
    ack_delay = 0;
    start_a = 8'h06;
    rst = 1'b0;
    checks++;
    if (wr_count != wc0)
      begin failures++; $display("FAIL sta_aborted: got %0d writes, want %0d", wr_count, wc0); end
    step_a(a, cyc, to);
    checks++;
    if (to || a !== 8'h06)
      begin failures++; $display("FAIL restart_addr: got %h, want 06", a); end
  endtask

  task automatic test_alu_table;
    logic [7:0] a; int cyc; bit to;
    pulse_reset(8'h20, 10'h000);
    for (int i = 0; i < 14; i++) begin
      step_a(a, cyc, to);
      checks++;
      if (to || {a, ac_a, carry_a, zero_a} !== ALU_EXP[i])
        begin failures++; $display("FAIL alu_step%0d: got addr=%h ac=%h c=%b z=%b, want %h", i, a, ac_a, carry_a, zero_a, ALU_EXP[i]); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_addr, wr_data, halted_a} !== {8'h89, 8'h3C, 1'b1})
      begin failures++; $display("FAIL sta_write: got addr=%h data=%h halted=%b, want 89 3C 1", wr_addr, wr_data, halted_a); end
  endtask

  task automatic test_wide;
    bit seen;
    pulse_reset(8'h00, 10'h200);
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (pc_en_b) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen || {addr_b, ac_b, carry_b, zero_b} !== WIDE_EXP[i])
        begin failures++; $display("FAIL wide_step%0d: got addr=%h ac=%h c=%b z=%b seen=%b, want %h", i, addr_b, ac_b, carry_b, zero_b, seen, WIDE_EXP[i]); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({halted_b, req_b} !== 2'b10)
      begin failures++; $display("FAIL wide_halt: got halted=%b req=%b, want 1 0", halted_b, req_b); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < 1024; i++) mem_b[i] = 16'h0000;
    mem_a[8'h06] = 16'h10F0; mem_a[8'h07] = 16'h9020; mem_a[8'h08] = 16'h5080;
    mem_a[8'h09] = 16'hB040; mem_a[8'h40] = 16'h1005; mem_a[8'h41] = 16'hB050;
    mem_a[8'h42] = 16'h2081; mem_a[8'h43] = 16'hA0FF; mem_a[8'hFF] = 16'h0000;
    mem_a[8'h00] = 16'hF000; mem_a[8'h80] = 16'h0010; mem_a[8'h81] = 16'h003C;
    mem_a[8'h10] = 16'h10A5; mem_a[8'h11] = 16'h3083;
    mem_a[8'h20] = 16'h1081; mem_a[8'h21] = 16'hD000; mem_a[8'h22] = 16'hC030;
    mem_a[8'h30] = 16'hE000; mem_a[8'h31] = 16'hC050; mem_a[8'h32] = 16'hE000;
    mem_a[8'h33] = 16'h8084; mem_a[8'h34] = 16'h6085; mem_a[8'h35] = 16'h7086;
    mem_a[8'h36] = 16'h3089; mem_a[8'h37] = 16'h4087; mem_a[8'h38] = 16'h5088;
    mem_a[8'h39] = 16'h0000; mem_a[8'h3A] = 16'hF000;
    mem_a[8'h84] = 16'h000F; mem_a[8'h85] = 16'h003C; mem_a[8'h86] = 16'h0030;
    mem_a[8'h87] = 16'h00C4; mem_a[8'h88] = 16'h0001;
    mem_b[10'h200] = 16'h1FF0; mem_b[10'h201] = 16'h9020;
    mem_b[10'h202] = 16'h5300; mem_b[10'h203] = 16'hF000;
    mem_b[10'h300] = 16'h0010;

    test_reset;
    test_arith;
    test_branch;
    test_wait_states;
    test_wrap_halt;
    test_reset_during_sta;
    test_alu_table;
    test_wide;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
